poly1305_seq: RTL

POLY1305_SEQ -- requirements
Module: poly1305_seq

---
 rtl/poly1305_seq_if.sv | 30 +++
 rtl/poly1305_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_seq_if.sv
// Message word stream into the Poly1305 sequencer.
//   din        32-bit message word, first byte at din[31:24]
//   din_valid  producer has a word on din
//   din_ready  sequencer accepts the word this cycle (valid & ready)
//   din_last   word is the final word of the message
//   din_bytes  valid bytes in the final word (0..4), ignored otherwise
// master modport: the producer side. slave modport: the sequencer side.
interface poly1305_seq_if;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        din_last;
    logic [2:0]  din_bytes;

    modport master (
        output din,
        output din_valid,
        output din_last,
        output din_bytes,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        input  din_last,
        input  din_bytes,
        output din_ready
    );
endinterface

// File: rtl/poly1305_seq.sv
// Poly1305 MAC sequencer: takes a one-time key and a stream of 32-bit message words, packs
// them into 16-byte blocks and drives init/next/finish commands into a poly1305 core.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, key, busy          begin a MAC (key sampled with start), busy while not idle
//   din_if                    message word stream (slave modport)
//   mac, mac_valid            tag (held) and one-cycle tag-valid pulse
//   blocks_done               core_next pulses since the last accepted start
//   core_*                    command/data interface to the poly1305 core
module poly1305_seq #(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [255:0]       key,
    output logic               busy,
    poly1305_seq_if.slave      din_if,
    output logic [127:0]       mac,
    output logic               mac_valid,
    output logic [CNT_W-1:0]   blocks_done,
    output logic               core_init,
    output logic               core_next,
    output logic               core_finish,
    output logic [255:0]       core_key,
    output logic [127:0]       core_block,
    output logic [4:0]         core_blocklen,
    input  logic               core_ready,
    input  logic [127:0]       core_mac
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCollect,
        StNext,
        StFinish,
        StWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic               settle_q, settle_d;
    logic [255:0]       key_q, key_d;
    logic [127:0]       block_q, block_d;
    logic [1:0]         word_idx_q, word_idx_d;
    logic [4:0]         byte_acc_q, byte_acc_d;
    logic [4:0]         blocklen_q, blocklen_d;
    logic               last_pend_q, last_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       mac_q, mac_d;

    logic               din_fire;
    logic [2:0]         word_bytes;
    logic [31:0]        byte_mask;
    logic [31:0]        din_masked;
    logic [4:0]         new_acc;
    logic               wait_exit;

    // Word decode: how many bytes this word contributes and which of them survive.
    always_comb begin
        din_fire = (state_q == StCollect) && din_if.din_valid;
        if (!din_if.din_last || (din_if.din_bytes > 3'd4)) begin
            word_bytes = 3'd4;
        end else begin
            word_bytes = din_if.din_bytes;
        end
        case (word_bytes)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hff00_0000;
            3'd2:    byte_mask = 32'hffff_0000;
            3'd3:    byte_mask = 32'hffff_ff00;
            default: byte_mask = 32'hffff_ffff;
        endcase
        din_masked = din_if.din & byte_mask;
        new_acc    = byte_acc_q + {2'b00, word_bytes};
        // The first WAIT cycle is skipped so the core has time to drop core_ready.
        wait_exit  = (state_q == StWait) && !settle_q && core_ready;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                end
            end
            StInit: state_d = StWait;
            StCollect: begin
                if (din_fire) begin
                    if (din_if.din_last && (new_acc == 5'd0)) begin
                        // Empty trailing block: nothing to absorb, go straight to finish.
                        state_d = StFinish;
                    end else if ((word_idx_q == 2'd3) || din_if.din_last) begin
                        state_d = StNext;
                    end
                end
            end
            StNext:   state_d = StWait;
            StFinish: state_d = StWait;
            StWait: begin
                if (wait_exit) begin
                    state_d = ret_q;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy             = (state_q != StIdle);
        din_if.din_ready = (state_q == StCollect);
        core_init        = (state_q == StInit);
        core_next        = (state_q == StNext);
        core_finish      = (state_q == StFinish);
        mac_valid        = (state_q == StDone);
    end

    // Datapath next state
    always_comb begin
        ret_d       = ret_q;
        settle_d    = 1'b0;
        key_d       = key_q;
        block_d     = block_q;
        word_idx_d  = word_idx_q;
        byte_acc_d  = byte_acc_q;
        blocklen_d  = blocklen_q;
        last_pend_d = last_pend_q;
        cnt_d       = cnt_q;
        mac_d       = mac_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    key_d       = key;
                    block_d     = '0;
                    word_idx_d  = '0;
                    byte_acc_d  = '0;
                    cnt_d       = '0;
                    last_pend_d = 1'b0;
                end
            end
            StInit: begin
                ret_d    = StCollect;
                settle_d = 1'b1;
            end
            StCollect: begin
                if (din_fire) begin
                    case (word_idx_q)
                        2'd0:    block_d[127:96] = din_masked;
                        2'd1:    block_d[95:64]  = din_masked;
                        2'd2:    block_d[63:32]  = din_masked;
                        default: block_d[31:0]   = din_masked;
                    endcase
                    byte_acc_d = new_acc;
                    if (din_if.din_last && (new_acc == 5'd0)) begin
                        last_pend_d = 1'b1;
                    end else if ((word_idx_q == 2'd3) || din_if.din_last) begin
                        blocklen_d  = new_acc;
                        last_pend_d = din_if.din_last;
                    end else begin
                        word_idx_d = word_idx_q + 2'd1;
                    end
                end
            end
            StNext: begin
                cnt_d    = cnt_q + CNT_W'(1);
                ret_d    = last_pend_q ? StFinish : StCollect;
                settle_d = 1'b1;
            end
            StFinish: begin
                ret_d    = StDone;
                settle_d = 1'b1;
            end
            StWait: begin
                if (wait_exit) begin
                    if (ret_q == StCollect) begin
                        block_d    = '0;
                        word_idx_d = '0;
                        byte_acc_d = '0;
                    end
                    // Captured on entry to DONE so mac is already valid alongside mac_valid.
                    if (ret_q == StDone) begin
                        mac_d = core_mac;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_q       <= StIdle;
            settle_q    <= 1'b0;
            key_q       <= '0;
            block_q     <= '0;
            word_idx_q  <= '0;
            byte_acc_q  <= '0;
            blocklen_q  <= '0;
            last_pend_q <= 1'b0;
            cnt_q       <= '0;
            mac_q       <= '0;
        end else begin
            ret_q       <= ret_d;
            settle_q    <= settle_d;
            key_q       <= key_d;
            block_q     <= block_d;
            word_idx_q  <= word_idx_d;
            byte_acc_q  <= byte_acc_d;
            blocklen_q  <= blocklen_d;
            last_pend_q <= last_pend_d;
            cnt_q       <= cnt_d;
            mac_q       <= mac_d;
        end
    end

    assign mac           = mac_q;
    assign blocks_done   = cnt_q;
    assign core_key      = key_q;
    assign core_block    = block_q;
    assign core_blocklen = blocklen_q;

endmodule
